keypad_scanner: RTL and testbench

Scans a 4x4 active-low push-button matrix, debounces it and reports single key presses as a one-cycle event with a 4-bit key code. It is the input-side counterpart of the LED matrix scan logic: it drives column strobes and reads row returns instead of driving rows and columns. It also maps four keys to the game's 2-bit direction encoding (0 up, 1 down, 2 left, 3 right). Consumers are the snake game core and any menu logic.

---
 rtl/keypad_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, debounces whole scan frames and
// reports single accepted key presses as one-cycle events, with a direction decode
// for the four game direction keys.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 10_000,
    parameter int unsigned DEBOUNCE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [1:0] dir,
    output logic       dir_valid
);

    localparam int unsigned     DivW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]      DebFrames = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {StIdle, StPressChk, StHeld, StReleaseChk} state_e;

    logic [3:0]      row_meta_q, row_sync_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      col_q;
    logic            sample, frame_done;
    logic [15:0]     mask_q, frame_mask;
    logic [4:0]      pop;
    logic [3:0]      single_code;
    logic            frame_none, frame_single;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc, cand_q, cand_d;
    logic       accept, release_ok;

    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d, key_held_q, key_held_d;
    logic [1:0] dir_q, dir_d;
    logic       dir_valid_q, dir_valid_d;

    // Two-flop synchronizer for the asynchronous row returns; idles at "nothing pressed".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= key_row;
            row_sync_q <= row_meta_q;
        end
    end

    // Dwell counter and column select; each column is strobed for SCAN_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            col_q <= 2'd0;
        end else if (sample) begin
            div_q <= '0;
            col_q <= col_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign sample     = (div_q == DivLast);
    assign frame_done = sample && (col_q == 2'd3);
    assign key_col    = ~(4'b0001 << col_q);

    // Press mask of the current frame with the column being sampled merged in; bit = row*4+col.
    always_comb begin
        frame_mask = mask_q;
        for (int unsigned r = 0; r < 4; r++) begin
            frame_mask[{r[1:0], col_q}] = ~row_sync_q[r[1:0]];
        end
    end

    // Store each column's presses at its sample point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if (sample) begin
            mask_q <= frame_mask;
        end
    end

    // Frame classification: population count plus the index of the (last) set bit.
    always_comb begin
        pop         = '0;
        single_code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (frame_mask[i]) begin
                pop         = pop + 5'd1;
                single_code = i[3:0];
            end
        end
    end

    assign frame_none   = (pop == 5'd0);
    assign frame_single = (pop == 5'd1);
    assign cnt_inc      = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    // Debounce FSM state and candidate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Debounce next-state: only evaluated when a frame closes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        accept     = 1'b0;
        release_ok = 1'b0;
        if (frame_done) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_single) begin
                        cand_d = single_code;
                        cnt_d  = 4'd1;
                        if (DebFrames == 4'd1) begin
                            accept  = 1'b1;
                            state_d = StHeld;
                        end else begin
                            state_d = StPressChk;
                        end
                    end
                end
                StPressChk: begin
                    if (!frame_single) begin
                        state_d = StIdle;
                    end else if (single_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DebFrames) begin
                            accept  = 1'b1;
                            state_d = StHeld;
                        end
                    end else begin
                        cand_d = single_code;
                        cnt_d  = 4'd1;
                    end
                end
                StHeld: begin
                    // Extra keys while held are ignored: no rollover, no auto-repeat.
                    if (frame_none) begin
                        cnt_d = 4'd1;
                        if (DebFrames == 4'd1) begin
                            release_ok = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            state_d = StReleaseChk;
                        end
                    end
                end
                StReleaseChk: begin
                    if (frame_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DebFrames) begin
                            release_ok = 1'b1;
                            state_d    = StIdle;
                        end
                    end else begin
                        state_d = StHeld;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output decode: event pulses, held flag and direction map.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = accept;
        key_held_d  = key_held_q;
        dir_d       = dir_q;
        dir_valid_d = 1'b0;
        if (accept) begin
            key_code_d = cand_d;
            key_held_d = 1'b1;
            case (cand_d)
                4'd1:    begin dir_d = 2'd0; dir_valid_d = 1'b1; end
                4'd9:    begin dir_d = 2'd1; dir_valid_d = 1'b1; end
                4'd4:    begin dir_d = 2'd2; dir_valid_d = 1'b1; end
                4'd6:    begin dir_d = 2'd3; dir_valid_d = 1'b1; end
                default: ;
            endcase
        end
        if (release_ok) begin
            key_held_d = 1'b0;
        end
    end

    // Registered outputs so pulses start the cycle after the closing sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            dir_q       <= '0;
            dir_valid_q <= 1'b0;
        end else begin
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign dir       = dir_q;
    assign dir_valid = dir_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios on a modelled 4x4 key matrix; expected key events
// are queued when keys are driven and matched against key_valid pulses by a monitor.
module tb_keypad_scanner;

    localparam int DIV   = 8;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * DIV;
    // Cycles counted from 1 at the first cycle of the first matching frame.
    localparam int LAT   = DEB * FRAME + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_row, key_col, key_code;
    logic        key_valid, key_held, dir_valid;
    logic [1:0]  dir;
    logic [15:0] pressed;

    int cyc;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        logic       dv;
        logic [1:0] dir;
    } ev_t;

    ev_t exp_q[$];

    keypad_scanner #(
        .SCAN_DIV       (DIV),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .dir      (dir),
        .dir_valid(dir_valid)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; cyc == k in the state after the k-th rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Key matrix: a row reads low when a pressed key sits on the currently strobed column.
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!key_col[c] && pressed[r*4+c]) key_row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s: got=%0d want=%0d (cyc=%0d)", tag, got, want, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_event(input int start, input logic [3:0] code, input logic dv,
                                input logic [1:0] d);
        ev_t e;
        e.cyc  = start + LAT - 1;
        e.code = code;
        e.dv   = dv;
        e.dir  = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " key_col"},   32'(key_col),   32'(4'b1110));
        check({tag, " key_code"},  32'(key_code),  32'd0);
        check({tag, " key_valid"}, 32'(key_valid), 32'd0);
        check({tag, " key_held"},  32'(key_held),  32'd0);
        check({tag, " dir"},       32'(dir),       32'd0);
        check({tag, " dir_valid"}, 32'(dir_valid), 32'd0);
    endtask

    // Monitor: column strobe sequence every cycle, and scoreboard match of each event pulse.
    always @(negedge clk) begin
        logic [3:0] exp_col;
        ev_t        e;
        exp_col = ~(4'b0001 << ((cyc / DIV) % 4));
        check("key_col", 32'(key_col), 32'(exp_col));
        if (key_valid === 1'b1) begin
            check("event expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("event cycle",     32'(cyc),       32'(e.cyc));
                check("event key_code",  32'(key_code),  32'(e.code));
                check("event dir_valid", 32'(dir_valid), 32'(e.dv));
                check("event dir",       32'(dir),       32'(e.dir));
            end
        end else begin
            check("dir_valid alone", 32'(dir_valid), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        pressed = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Idle scanning for two frames, then code 9 (row 2 col 1, down) from frame 2.
        wait_cyc(2 * FRAME);
        pressed = 16'h0200;
        expect_event(2 * FRAME, 4'd9, 1'b1, 2'd1);
        wait_cyc(2 * FRAME + LAT);
        check("t1 drained", 32'(exp_q.size()), 32'd0);
        check("t1 key_code", 32'(key_code), 32'd9);
        check("t1 dir", 32'(dir), 32'd1);
        wait_cyc(7 * FRAME);
        check("t1 held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_cyc(10 * FRAME - 1);
        check("t1 held before release", 32'(key_held), 32'd1);
        wait_cyc(10 * FRAME);
        check("t1 released", 32'(key_held), 32'd0);

        // Code 15: event without direction, dir keeps 1.
        pressed = 16'h8000;
        expect_event(10 * FRAME, 4'd15, 1'b0, 2'd1);
        wait_cyc(10 * FRAME + LAT);
        check("t2 drained", 32'(exp_q.size()), 32'd0);
        check("t2 key_code", 32'(key_code), 32'd15);
        check("t2 dir kept", 32'(dir), 32'd1);
        wait_cyc(14 * FRAME);
        pressed = '0;
        wait_cyc(17 * FRAME);
        check("t2 released", 32'(key_held), 32'd0);

        // Bounce: code 6 for 2 frames, gone 1, then 3 frames -> one event.
        pressed = 16'h0040;
        wait_cyc(19 * FRAME);
        pressed = '0;
        wait_cyc(20 * FRAME);
        pressed = 16'h0040;
        expect_event(20 * FRAME, 4'd6, 1'b1, 2'd3);
        wait_cyc(20 * FRAME + LAT);
        check("t3 drained", 32'(exp_q.size()), 32'd0);
        check("t3 key_code", 32'(key_code), 32'd6);
        check("t3 dir", 32'(dir), 32'd3);
        // One-frame dropout while held: no second event, still held.
        wait_cyc(24 * FRAME);
        pressed = '0;
        wait_cyc(25 * FRAME);
        pressed = 16'h0040;
        wait_cyc(27 * FRAME - 1);
        check("t3 held after dropout", 32'(key_held), 32'd1);
        wait_cyc(27 * FRAME);
        pressed = '0;
        wait_cyc(30 * FRAME);
        check("t3 released", 32'(key_held), 32'd0);

        // Hold code 4, then add code 1: no extra event.
        pressed = 16'h0010;
        expect_event(30 * FRAME, 4'd4, 1'b1, 2'd2);
        wait_cyc(30 * FRAME + LAT);
        check("t4 drained", 32'(exp_q.size()), 32'd0);
        check("t4 key_code", 32'(key_code), 32'd4);
        check("t4 dir", 32'(dir), 32'd2);
        wait_cyc(34 * FRAME);
        pressed = 16'h0012;
        wait_cyc(38 * FRAME);
        check("t4 held with extra", 32'(key_held), 32'd1);
        check("t4 code unchanged", 32'(key_code), 32'd4);
        pressed = '0;
        wait_cyc(41 * FRAME);
        check("t4 released", 32'(key_held), 32'd0);
        // Two keys from idle: no event.
        pressed = 16'h0012;
        wait_cyc(45 * FRAME);
        check("t4 multi no hold", 32'(key_held), 32'd0);
        check("t4 multi code kept", 32'(key_code), 32'd4);
        check("t4 multi dir kept", 32'(dir), 32'd2);

        // Reset while code 6 has matched two frames.
        pressed = 16'h0040;
        wait_cyc(47 * FRAME + 10);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("mid reset");
        @(negedge clk);
        reset = 1'b0;
        expect_event(0, 4'd6, 1'b1, 2'd3);
        wait_cyc(LAT - 2);
        check("t5 no early hold", 32'(key_held), 32'd0);
        check("t5 code still reset", 32'(key_code), 32'd0);
        wait_cyc(LAT);
        check("t5 drained", 32'(exp_q.size()), 32'd0);
        check("t5 key_code", 32'(key_code), 32'd6);
        check("t5 held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_cyc(LAT + 2 * FRAME);

        check("final queue empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
